// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_ctrl_pkg;

  localparam int OPW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the one that did not win last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters, one operation in flight at a time.
// Handshake: a transfer happens on a rising edge where valid and ready are both high on that channel.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*N-1:0]   req_opa,
  input  logic [2*N-1:0]   req_opb,
  input  logic [2*OPW-1:0] req_opcode,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [N-1:0]     alu_opa,
  output logic [N-1:0]     alu_opb,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [N-1:0]     alu_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           gid_q, gid_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic [N-1:0]   result_q, result_d;

  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opc_d        = opc_q;
    result_d     = result_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        // gnt is non-zero exactly when some requester is valid, so that is an accept.
        if (gnt != 2'b00) begin
          opa_d        = gnt_id ? req_opa[2*N-1:N] : req_opa[N-1:0];
          opb_d        = gnt_id ? req_opb[2*N-1:N] : req_opb[N-1:0];
          opc_d        = gnt_id ? req_opcode[2*OPW-1:OPW] : req_opcode[OPW-1:0];
          gid_d        = gnt_id;
          last_grant_d = gnt_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[gid_q] = 1'b1;
        if (rsp_ready[gid_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      opc_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opc_q        <= opc_d;
      result_q     <= result_d;
    end
  end

  assign alu_opa    = opa_q;
  assign alu_opb    = opb_q;
  assign alu_opcode = opc_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an adder standing in for the shared ALU.
module tb_alu_share_ctrl;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_opa;
  logic [2*N-1:0] req_opb;
  logic [5:0]     req_opcode;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [N-1:0]   rsp_result;
  logic [N-1:0]   alu_opa;
  logic [N-1:0]   alu_opb;
  logic [2:0]     alu_opcode;
  logic [N-1:0]   alu_out;
  logic           busy;
  logic [1:0]     dbg_state;

  int checks;
  int failures;

  alu_share_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_opa    (alu_opa),
    .alu_opb    (alu_opb),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  assign alu_out = alu_opa + alu_opb;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_opa    = '0;
    req_opb    = '0;
    req_opcode = '0;
    rsp_ready  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // drivers
  task automatic set_req(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] opc);
    req_opa[idx*N +: N]    = a;
    req_opb[idx*N +: N]    = b;
    req_opcode[idx*3 +: 3] = opc;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ready, rsp_valid, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, rsp_valid, busy});
    end
    checks++;
    if ({rsp_result, alu_opa, alu_opb, alu_opcode} !== 27'b0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {rsp_result, alu_opa, alu_opb, alu_opcode});
    end
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready = 2'b01;
    set_req(0, 8'd17, 8'd9, 3'd2);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1 || alu_opcode !== 3'd2 || alu_opa !== 8'd17
        || alu_opb !== 8'd9 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_exec got busy=%b st=%0d opc=%0d a=%0d b=%0d rv=%b exp 1 1 2 17 9 00",
               busy, dbg_state, alu_opcode, alu_opa, alu_opb, rsp_valid);
    end
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 8'd26) begin
      failures++;
      $display("FAIL single_resp got rv=%b res=%0d exp rv=01 res=26", rsp_valid, rsp_result);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got busy=%b rv=%b exp 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]   exp_g;
    logic [N-1:0] exp_r;
    apply_reset();
    rsp_ready = 2'b11;
    set_req(0, 8'd1, 8'd2, 3'd0);
    set_req(1, 8'd10, 8'd20, 3'd1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 8'd3 : 8'd30;
      #1;
      checks++;
      if (req_ready !== exp_g) begin
        failures++;
        $display("FAIL alt_grant%0d got=%b exp=%b", k, req_ready, exp_g);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== exp_g || rsp_result !== exp_r) begin
        failures++;
        $display("FAIL alt_resp%0d got rv=%b res=%0d exp rv=%b res=%0d",
                 k, rsp_valid, rsp_result, exp_g, exp_r);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_busy_block();
    apply_reset();
    rsp_ready = 2'b11;
    set_req(1, 8'd5, 8'd6, 3'd3);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL busy_first_ready got=%b exp=10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    set_req(0, 8'd7, 8'd8, 3'd4);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL busy_exec_ready got=%b exp=00", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_result !== 8'd11) begin
      failures++;
      $display("FAIL busy_resp got rdy=%b rv=%b res=%0d exp 00 10 11", req_ready, rsp_valid, rsp_result);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL busy_idle_ready got=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (alu_opa !== 8'd7 || alu_opb !== 8'd8 || alu_opcode !== 3'd4) begin
      failures++;
      $display("FAIL busy_second_ops got a=%0d b=%0d opc=%0d exp 7 8 4", alu_opa, alu_opb, alu_opcode);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 8'd15) begin
      failures++;
      $display("FAIL busy_second_resp got rv=%b res=%0d exp 01 15", rsp_valid, rsp_result);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 2'b00;
    set_req(1, 8'd200, 8'd100, 3'd0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 8'd44) begin
        failures++;
        $display("FAIL bp_hold%0d got rv=%b res=%0d exp 10 44", k, rsp_valid, rsp_result);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL bp_release got busy=%b rv=%b exp 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_wrong_ready();
    apply_reset();
    rsp_ready = 2'b00;
    set_req(0, 8'd3, 8'd4, 3'd6);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 2'b10;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || rsp_valid !== 2'b01 || rsp_result !== 8'd7) begin
      failures++;
      $display("FAIL wrong_ready got st=%0d rv=%b res=%0d exp 2 01 7", dbg_state, rsp_valid, rsp_result);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wrong_ready_release got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 2'b11;
    set_req(0, 8'd50, 8'd60, 3'd5);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_opa !== 8'd50) begin
      failures++;
      $display("FAIL rstmid_exec got busy=%b a=%0d exp 1 50", busy, alu_opa);
    end
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy} !== 5'b0 || {rsp_result, alu_opa, alu_opb, alu_opcode} !== 27'b0) begin
      failures++;
      $display("FAIL rstmid_values got ctl=%b data=%h exp 0 0",
               {req_ready, rsp_valid, busy}, {rsp_result, alu_opa, alu_opb, alu_opcode});
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL rstmid_norsp%0d got=%b exp=00", k, rsp_valid);
      end
    end
    set_req(0, 8'd33, 8'd44, 3'd1);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_accept got=%b exp=01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 8'd77) begin
      failures++;
      $display("FAIL rstmid_resp got rv=%b res=%0d exp 01 77", rsp_valid, rsp_result);
    end
    @(negedge clk);
  endtask

  // final report
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_alternate();
    test_busy_block();
    test_backpressure();
    test_wrong_ready();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
